dma_priority_arbiter: RTL

//  Request arbiter and bus-hold sequencer for the 4-channel DMA controller.
//  - Collects hardware DREQ and software request bits, applies mask and polarity, and picks one channel.
//  - Runs the HRQ/HLDA handshake with the CPU and drives DACK for the granted channel.
//  - Holds the grant until the transfer timing engine reports end of service.
//  - Sits between the command/mode/mask/request registers and the transfer timing engine.

---
 rtl/dma_arbiter_pkg.sv | 44 ++++
 rtl/dma_priority_encoder.sv | 23 ++
 rtl/dma_priority_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dma_arbiter_pkg.sv
// Shared types and the priority pick function for the DMA request arbiter.
//   arb_state_t : bus-hold sequencer states
//   ch_t        : 2-bit channel select
//   win_t       : {found, ch} result of a priority pick
//   next_winner : fixed (0>1>2>3) or rotating pick starting at low_pri+1
package dma_arbiter_pkg;

   localparam int unsigned NumCh = 4;

   typedef logic [1:0] ch_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVE   = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   typedef struct packed {
      logic found;
      ch_t  ch;
   } win_t;

   // Scan from lowest to highest priority so the last hit is the winner.
   function automatic win_t next_winner(input logic [NumCh-1:0] eff,
                                        input ch_t              low_pri,
                                        input logic             rotate);
      win_t w;
      ch_t  base;
      ch_t  idx;
      w.found = 1'b0;
      w.ch    = '0;
      base    = rotate ? ch_t'(low_pri + 2'd1) : 2'd0;
      for (int i = NumCh - 1; i >= 0; i--) begin
         idx = ch_t'(base + ch_t'(i));
         if (eff[idx]) begin
            w.found = 1'b1;
            w.ch    = idx;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational 4-way priority pick, fixed or rotating.
//   eff_i     : effective request vector
//   low_pri_i : channel that currently has lowest priority (rotating mode only)
//   rotate_i  : 0 = fixed 0>1>2>3, 1 = rotating
//   found_o   : at least one request present
//   ch_o      : winning channel (valid when found_o=1)
module dma_priority_encoder
   import dma_arbiter_pkg::*;
(
   input  logic [NumCh-1:0] eff_i,
   input  ch_t              low_pri_i,
   input  logic             rotate_i,
   output logic             found_o,
   output ch_t              ch_o
);

   win_t win;

   assign win     = next_winner(eff_i, low_pri_i, rotate_i);
   assign found_o = win.found;
   assign ch_o    = win.ch;

endmodule

// File: rtl/dma_priority_arbiter.sv
// Request arbiter and bus-hold sequencer for the 4-channel DMA controller.
// Combines hardware DREQ and software requests, runs the HRQ/HLDA handshake and
// holds DACK on the granted channel until the timing engine signals serviceDone.
//
// Ports:
//   CLK, RESET    : clock, asynchronous active-high reset
//   DREQ          : raw channel request pins
//   softReq       : software request bits (never masked, never synchronized)
//   mask          : 1 = ignore hardware DREQ on that channel
//   cmdDisable    : blocks new arbitration (IDLE->REQ only)
//   cmdRotate     : 0 = fixed priority, 1 = rotating priority
//   cmdDreqLow    : DREQ sensed active low
//   cmdDackHigh   : DACK driven active high
//   HLDA          : hold acknowledge from CPU
//   serviceDone   : 1-cycle end-of-service pulse
//   HRQ           : hold request to CPU
//   DACK          : channel acknowledge
//   grantValid    : a channel is in service
//   grantCh       : channel in service
//
// Build option: define DMA_DREQ_SYNC_EN to pass DREQ through a 2-flop
// synchronizer (DREQ-to-HRQ latency 3 cycles instead of 1).
module dma_priority_arbiter
   import dma_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CH = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NUM_CH-1:0] DREQ,
   input  logic [NUM_CH-1:0] softReq,
   input  logic [NUM_CH-1:0] mask,
   input  logic              cmdDisable,
   input  logic              cmdRotate,
   input  logic              cmdDreqLow,
   input  logic              cmdDackHigh,
   input  logic              HLDA,
   input  logic              serviceDone,
   output logic              HRQ,
   output logic [NUM_CH-1:0] DACK,
   output logic              grantValid,
   output ch_t               grantCh
);

   arb_state_t        state_q, state_d;
   ch_t               grant_ch_q, grant_ch_d;
   ch_t               low_pri_q, low_pri_d;
   logic [NUM_CH-1:0] dreq_s;
   logic [NUM_CH-1:0] eff;
   logic [NUM_CH-1:0] dack_act;
   logic              win_found;
   ch_t               win_ch;

`ifdef DMA_DREQ_SYNC_EN
   logic [NUM_CH-1:0] dreq_meta_q, dreq_sync_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         dreq_meta_q <= '0;
         dreq_sync_q <= '0;
      end else begin
         dreq_meta_q <= DREQ;
         dreq_sync_q <= dreq_meta_q;
      end
   end

   assign dreq_s = dreq_sync_q;
`else
   assign dreq_s = DREQ;
`endif

   // Polarity is applied before the mask; software requests bypass both.
   assign eff = softReq | (~mask & (dreq_s ^ {NUM_CH{cmdDreqLow}}));

   dma_priority_encoder u_enc (
      .eff_i     (eff),
      .low_pri_i (low_pri_q),
      .rotate_i  (cmdRotate),
      .found_o   (win_found),
      .ch_o      (win_ch)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         grant_ch_q <= '0;
         low_pri_q  <= 2'd3;
      end else begin
         state_q    <= state_d;
         grant_ch_q <= grant_ch_d;
         low_pri_q  <= low_pri_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_ch_d = grant_ch_q;
      low_pri_d  = low_pri_q;
      case (state_q)
         IDLE: begin
            if (!cmdDisable && (|eff)) state_d = REQ;
         end
         REQ: begin
            // Arbitration happens in the HLDA cycle, so a withdrawn request
            // releases the bus without ever asserting DACK.
            if (HLDA) begin
               if (win_found) begin
                  grant_ch_d = win_ch;
                  state_d    = SERVE;
               end else begin
                  state_d = RELEASE;
               end
            end
         end
         SERVE: begin
            if (serviceDone) begin
               if (cmdRotate) low_pri_d = grant_ch_q;
               // HLDA already gone means no release wait is needed.
               state_d = HLDA ? RELEASE : IDLE;
            end else if (!HLDA) begin
               state_d = IDLE;
            end
         end
         RELEASE: begin
            if (!HLDA) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign HRQ        = (state_q == REQ) || (state_q == SERVE);
   assign grantValid = (state_q == SERVE);
   assign grantCh    = grant_ch_q;
   assign dack_act   = grantValid ? (NUM_CH'(1) << grant_ch_q) : '0;
   assign DACK       = cmdDackHigh ? dack_act : ~dack_act;

endmodule
